// File: rtl/data_memory_ctrl.sv
// Byte-addressed MEM-stage data memory.
// Byte/word access, registered reads, post-reset clear.
module data_memory_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int BIG_ENDIAN = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  memWrite,
  input  logic                  memRead,
  input  logic                  size,
  input  logic [15:0]           address,
  input  logic [DATA_WIDTH-1:0] writeData,
  output logic [DATA_WIDTH-1:0] readData,
  output logic                  readValid,
  output logic                  busy,
  output logic                  error
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LB    = $clog2(BYTES);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(BYTES);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - BYTES);

  typedef enum logic {INIT, IDLE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [7:0]            mem [DEPTH];

  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] base;
  logic                  idle;
  logic                  legal;
  logic                  do_wr;
  logic                  do_rd;
  logic [7:0]            wbyte [BYTES];
  logic [BYTES-1:0]      wen;
  logic [DATA_WIDTH-1:0] rword;
  logic [DATA_WIDTH-1:0] rnext;

  assign addr  = address[ADDR_WIDTH-1:0];
  assign idle  = (state_q == IDLE);
  assign legal = ((32'(address) >> ADDR_WIDTH) == 32'd0)
               && (!size || (address[LB-1:0] == '0));
  assign do_wr = idle && memWrite && legal;
  assign do_rd = idle && memRead;
  assign busy  = (state_q == INIT);
  assign base  = idle ? addr : ptr_q;

  // FSM state and clear pointer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // clear sequencing: one word per cycle until the top
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      INIT: begin
        ptr_d = ptr_q + STEP;
        if (ptr_q == LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // byte lanes to store: zeros while clearing, else ordered data
  always_comb begin
    for (int i = 0; i < BYTES; i++) begin
      wbyte[i] = '0;
      wen[i]   = 1'b0;
      if (busy) begin
        wen[i] = 1'b1;
      end else begin
        if (BIG_ENDIAN != 0)
          wbyte[i] = writeData[DATA_WIDTH-1-8*i -: 8];
        else
          wbyte[i] = writeData[8*i +: 8];
        wen[i] = do_wr && (size || (i == 0));
      end
    end
    if (!busy && !size) wbyte[0] = writeData[7:0];
  end

  // array write; left alone while reset is held low
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BYTES; i++) begin
        if (wen[i]) mem[base + ADDR_WIDTH'(i)] <= wbyte[i];
      end
    end
  end

  // load data: array word, or the store data when writing too
  always_comb begin
    rword = '0;
    for (int i = 0; i < BYTES; i++) begin
      if (BIG_ENDIAN != 0)
        rword[DATA_WIDTH-1-8*i -: 8] = mem[addr + ADDR_WIDTH'(i)];
      else
        rword[8*i +: 8] = mem[addr + ADDR_WIDTH'(i)];
    end
    rnext = '0;
    if (legal) begin
      if (memWrite)
        rnext = size ? writeData : {{(DATA_WIDTH-8){1'b0}}, writeData[7:0]};
      else
        rnext = size ? rword : {{(DATA_WIDTH-8){1'b0}}, mem[addr]};
    end
  end

  // registered load result and status pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      readData  <= '0;
      readValid <= 1'b0;
      error     <= 1'b0;
    end else begin
      readValid <= do_rd;
      error     <= idle && (memRead || memWrite) && !legal;
      if (do_rd) readData <= rnext;
    end
  end

endmodule
